seq_mul_arbiter: RTL and testbench
==================================

# seq_mul_arbiter

Round-robin arbiter and sequencer that shares one sequential (repeated-addition) multiplier datapath among NREQ requesters. It accepts operand pairs from requesters, issues one multiply at a time to the shared multiplier through a start/done handshake, and returns each product to its owner. Zero operands are answered without using the multiplier. A watchdog aborts a hung multiply. It sits between the client blocks and the multiplier's datapath/control pair.

## Interface
- NREQ, 4, number of requesters (2..8)
- W, 16, operand width; product width is 2*W
- TMO, 70000, max cycles to wait for mul_done; 0 disables the watchdog
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req  in  NREQ  per-requester request; held high until its gnt bit is seen
- a_in  in  NREQ*W  operand A of requester i at bits [i*W +: W]
- b_in  in  NREQ*W  operand B, same packing
- gnt  out  NREQ  one-hot, one-cycle pulse: the request has been accepted
- rsp_valid  out  NREQ  one-hot, one-cycle pulse: the result is on rsp_data
- rsp_data  out  2*W  product, valid only while any rsp_valid bit is high
- rsp_err  out  1  qualifies rsp_valid: watchdog expired, rsp_data=0
- mul_start  out  1  one-cycle start pulse to the multiplier
- mul_a, mul_b  out  W each  operands to the multiplier, stable from ISSUE through WAIT
- mul_done  in  1  multiplier completion pulse
- mul_p  in  2*W  multiplier product, sampled in the mul_done cycle
- busy  out  1  high whenever state != IDLE

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any req is high, the winner is the first set bit at or after rr_ptr, searching upward with wrap at NREQ. At that edge the arbiter latches the winner's a/b and owner index.
  - If the latched a==0 or b==0, go to RESP with product 0 (zero shortcut). gnt and rsp_valid both pulse in that RESP cycle. mul_start is never asserted.
  - Otherwise go to ISSUE.
- ISSUE: gnt[owner]=1 and mul_start=1 for this cycle. Clear the watchdog counter and go to WAIT.
- WAIT: increment the counter each cycle.
  - On mul_done, latch mul_p and go to RESP with rsp_err=0.
  - If TMO!=0 and the counter reaches TMO-1 without mul_done, go to RESP with rsp_err=1 and rsp_data=0.
- RESP: rsp_valid[owner]=1 and rsp_data/rsp_err are driven for one cycle. Set rr_ptr=(owner+1) mod NREQ and go to IDLE.
- rr_ptr advances only on completion, including error and zero-shortcut completions.
- req is sampled only in IDLE. A requester that keeps req high after gnt is re-arbitrated as a new request.
- mul_done is ignored outside WAIT. This covers spurious done pulses and a done in the ISSUE cycle.
- Multiplication is unsigned. Products need no truncation because the result is 2*W wide.

## Timing
- Reset values: state=IDLE, rr_ptr=0. gnt, rsp_valid, rsp_data, rsp_err, mul_start, mul_a, mul_b and busy are all 0.
- rst mid-operation: the transaction is dropped with no rsp_valid. mul_start is 0 in the cycle after the rst edge. The multiplier shares rst.
- Normal path: req sampled at edge E0; ISSUE in cycle E0..E1 (gnt, mul_start); WAIT from E1 onward. A mul_done seen at edge Ed gives RESP in cycle Ed..Ed+1, then IDLE.
- Minimum request-to-response latency is 3 cycles (mul_done in the first WAIT cycle).
- Zero shortcut: gnt and rsp_valid appear in the first cycle after E0. The next arbitration is at the following edge.
- Back-to-back: a new request can be sampled in the IDLE cycle directly after RESP, so accepted requests are at least 2 cycles apart.
- If all requests are low in IDLE, the block stays in IDLE and rr_ptr is unchanged.

## Test plan
- Single request: req[1] with a=3, b=5; model multiplier returns done after 5 WAIT cycles with mul_p=15. Expect gnt[1] and mul_start in the same cycle, mul_a=3 and mul_b=5 stable until done, rsp_valid[1] with rsp_data=15 and rsp_err=0 one cycle after done, busy low after that.
- Round robin: all four req held high continuously. Expect grant order 0,1,2,3,0. Then after reset, req[2] and req[3] held high: expect 2,3,2.
- Zero shortcut: req[0] with a=0, b=9. Expect gnt[0] and rsp_valid[0] in the same cycle, rsp_data=0, mul_start never high. Repeat with a=7, b=0.
- Boundary operands: a=b=16'hFFFF. Expect rsp_data=32'hFFFE0001.
- Watchdog: TMO=8 with mul_done withheld. Expect rsp_valid with rsp_err=1 and rsp_data=0 eight cycles after ISSUE, rr_ptr advanced. Then a spurious mul_done in IDLE must be ignored.
- Reset mid-WAIT: assert rst for one cycle during WAIT. Expect all outputs 0 next cycle, no rsp_valid, and the next grant to start from requester 0.

Source files
------------

// File: rtl/seq_mul_arbiter.sv
// ---------------------------------------------------------------------------
// seq_mul_arbiter
//
// Shares one sequential multiplier among NREQ requesters. Requests are
// arbitrated round-robin while the block is idle. The winner's operands are
// latched and then handled in one of two ways:
//   * If either operand is zero, the product is known to be 0. The block
//     answers directly, and gnt and rsp_valid pulse together in one RESP cycle.
//   * Otherwise the operands go to the multiplier with a one-cycle mul_start.
//     The block then waits for mul_done and returns mul_p to the owner.
// A watchdog bounds the wait. If it expires, the owner gets a response with
// rsp_err=1 and rsp_data=0, so a hung multiplier cannot stall the clients.
//
// Ports
//   clk, rst      rising-edge clock; synchronous active-high reset
//   req           per-requester request, held until its gnt bit is seen
//   a_in, b_in    packed operands; requester i uses bits [i*W +: W]
//   gnt           one-hot pulse: request accepted
//   rsp_valid     one-hot pulse: product on rsp_data for that requester
//   rsp_data      2*W-bit product, zero when no rsp_valid bit is high
//   rsp_err       qualifies rsp_valid: watchdog expired, rsp_data is 0
//   mul_start     one-cycle start pulse to the multiplier
//   mul_a, mul_b  operands to the multiplier, held from ISSUE through WAIT
//   mul_done      multiplier completion pulse (honoured only in WAIT)
//   mul_p         multiplier product, sampled in the mul_done cycle
//   busy          high whenever the sequencer is not idle
//
// Parameters
//   NREQ  number of requesters (2..8)
//   W     operand width
//   TMO   watchdog limit in cycles; 0 disables the watchdog
// ---------------------------------------------------------------------------
module seq_mul_arbiter #(
    parameter int NREQ = 4,
    parameter int W    = 16,
    parameter int TMO  = 70000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] a_in,
    input  logic [NREQ*W-1:0] b_in,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [2*W-1:0]    rsp_data,
    output logic              rsp_err,
    output logic              mul_start,
    output logic [W-1:0]      mul_a,
    output logic [W-1:0]      mul_b,
    input  logic              mul_done,
    input  logic [2*W-1:0]    mul_p,
    output logic              busy
);

    // -----------------------------------------------------------------------
    // Local sizing
    // -----------------------------------------------------------------------
    localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;  // owner / pointer width
    localparam int CW = (TMO > 2) ? $clog2(TMO) : 1;    // holds 0..TMO-1

    // The response is due once the counter, after this cycle's increment,
    // reaches TMO-1. That puts the RESP cycle TMO cycles after the ISSUE
    // cycle. TMO=1 degenerates to a one-cycle wait.
    localparam logic [CW:0] TMO_LIM = (CW+1)'((TMO >= 2) ? TMO - 1 : 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_t          state_q,  state_d;
    logic [OW-1:0]   rr_ptr_q, rr_ptr_d;   // first requester to consider
    logic [OW-1:0]   owner_q,  owner_d;    // requester being served
    logic [W-1:0]    a_q,      a_d;
    logic [W-1:0]    b_q,      b_d;
    logic [2*W-1:0]  p_q,      p_d;        // product returned in RESP
    logic            err_q,    err_d;      // watchdog expired
    logic            zero_q,   zero_d;     // answered by the zero shortcut
    logic [CW-1:0]   cnt_q,    cnt_d;      // watchdog counter

    // -----------------------------------------------------------------------
    // Operand unpacking
    // -----------------------------------------------------------------------
    logic [W-1:0] a_arr [NREQ];
    logic [W-1:0] b_arr [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign a_arr[g] = a_in[g*W +: W];
        assign b_arr[g] = b_in[g*W +: W];
    end

    // -----------------------------------------------------------------------
    // Round-robin winner: first set req bit at or after rr_ptr_q, with wrap.
    // -----------------------------------------------------------------------
    logic          win_found;
    logic [OW-1:0] win_idx;

    always_comb begin
        logic [OW:0] k;  // one spare bit so the wrap comparison cannot overflow
        // NOTE: every variable written here gets a value before any branch;
        // otherwise a path that skips the assignment would infer a latch.
        k         = '0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            k = {1'b0, rr_ptr_q} + (OW+1)'(i);
            if (k >= (OW+1)'(NREQ)) begin
                k = k - (OW+1)'(NREQ);
            end
            if (!win_found && req[k[OW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = k[OW-1:0];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Watchdog
    // -----------------------------------------------------------------------
    logic [CW:0] cnt_next;
    logic        timeout;

    assign cnt_next = {1'b0, cnt_q} + (CW+1)'(1);
    assign timeout  = (TMO != 0) && (cnt_next >= TMO_LIM);

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        a_d      = a_q;
        b_d      = b_q;
        p_d      = p_q;
        err_d    = err_q;
        zero_d   = zero_q;
        cnt_d    = cnt_q;

        unique case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    owner_d = win_idx;
                    a_d     = a_arr[win_idx];
                    b_d     = b_arr[win_idx];
                    p_d     = '0;
                    err_d   = 1'b0;
                    if ((a_arr[win_idx] == '0) || (b_arr[win_idx] == '0)) begin
                        // A zero operand makes the product 0. Skip the multiplier.
                        zero_d  = 1'b1;
                        state_d = S_RESP;
                    end else begin
                        zero_d  = 1'b0;
                        state_d = S_ISSUE;
                    end
                end
            end

            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end

            S_WAIT: begin
                // A real completion wins over an expiry in the same cycle.
                if (mul_done) begin
                    p_d     = mul_p;
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end else if (timeout) begin
                    p_d     = '0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_next[CW-1:0];
                end
            end

            S_RESP: begin
                // Every completion moves the pointer past the served owner,
                // including error and zero-shortcut completions.
                rr_ptr_d = (owner_q == OW'(NREQ - 1)) ? '0 : owner_q + OW'(1);
                state_d  = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: state is written with non-blocking assignments so that every
        // flop samples the pre-edge values, whatever order the lines appear in.
        if (rst) begin
            state_q  <= S_IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            // NOTE: the operand and product registers are reset too, not only
            // the control state. mul_a/mul_b are driven straight from them and
            // must read 0 right after reset.
            a_q      <= '0;
            b_q      <= '0;
            p_q      <= '0;
            err_q    <= 1'b0;
            zero_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            a_q      <= a_d;
            b_q      <= b_d;
            p_q      <= p_d;
            err_q    <= err_d;
            zero_q   <= zero_d;
            cnt_q    <= cnt_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs: decoded from registered state only, so they are glitch-free
    // one-cycle pulses aligned to the state they belong to.
    // -----------------------------------------------------------------------
    logic [NREQ-1:0] owner_oh;

    assign owner_oh = NREQ'(1) << owner_q;

    always_comb begin
        gnt       = '0;
        rsp_valid = '0;
        rsp_data  = '0;
        rsp_err   = 1'b0;
        mul_start = 1'b0;

        unique case (state_q)
            S_ISSUE: begin
                gnt       = owner_oh;
                mul_start = 1'b1;
            end
            S_RESP: begin
                rsp_valid = owner_oh;
                rsp_data  = p_q;
                rsp_err   = err_q;
                // The zero shortcut never passes through ISSUE, so its grant
                // is given together with the response.
                if (zero_q) begin
                    gnt = owner_oh;
                end
            end
            default: begin
            end
        endcase
    end

    assign mul_a = a_q;
    assign mul_b = b_q;
    assign busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_seq_mul_arbiter.sv
// ---------------------------------------------------------------------------
// tb_seq_mul_arbiter
//
// Directed bench for seq_mul_arbiter with NREQ=4, W=16 and a short watchdog
// (TMO=8). A small multiplier model drives mul_done/mul_p. The model counts
// done_delay cycles after mul_start and can be told to withhold the result or
// to inject a stray done pulse. Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_seq_mul_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 16;
    localparam int TMO  = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NREQ-1:0]   req = '0;
    logic [NREQ*W-1:0] a_in = '0;
    logic [NREQ*W-1:0] b_in = '0;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   rsp_valid;
    logic [2*W-1:0]    rsp_data;
    logic              rsp_err;
    logic              mul_start;
    logic [W-1:0]      mul_a;
    logic [W-1:0]      mul_b;
    logic              mul_done = 1'b0;
    logic [2*W-1:0]    mul_p = '0;
    logic              busy;

    int n_vec = 0;
    int n_err = 0;

    // multiplier model controls
    int done_delay  = 1;
    bit withhold    = 1'b0;
    bit inject_done = 1'b0;
    int mcnt        = 0;

    seq_mul_arbiter #(.NREQ(NREQ), .W(W), .TMO(TMO)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .a_in      (a_in),
        .b_in      (b_in),
        .gnt       (gnt),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .mul_start (mul_start),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_done  (mul_done),
        .mul_p     (mul_p),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Multiplier model: updates 2 ns after each rising edge. With
    // done_delay=N, mul_done is high in the N-th WAIT cycle.
    always @(posedge clk) begin
        #2;
        if (rst) begin
            mcnt     = 0;
            mul_done = 1'b0;
            mul_p    = '0;
        end else begin
            mul_done = inject_done;
            if (mul_start) begin
                mcnt = done_delay;
            end else if (mcnt > 0) begin
                mcnt = mcnt - 1;
                if (mcnt == 0 && !withhold) begin
                    mul_done = 1'b1;
                    mul_p    = {16'h0000, mul_a} * {16'h0000, mul_b};
                end
            end
        end
    end

    function automatic int oh_idx(input logic [NREQ-1:0] v);
        if ($countones(v) != 1) return -1;
        for (int i = 0; i < NREQ; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic set_ops(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        a_in[i*W +: W] = a;
        b_in[i*W +: W] = b;
    endtask

    task automatic wait_rsp(input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (rsp_valid !== '0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_idle(input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // -----------------------------------------------------------------------
    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_vec++; if (gnt !== 4'b0000) begin n_err++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
        n_vec++; if (rsp_valid !== 4'b0000) begin n_err++; $display("FAIL reset_rsp_valid: got %b want 0000", rsp_valid); end
        n_vec++; if (rsp_data !== 32'd0) begin n_err++; $display("FAIL reset_rsp_data: got %h want 0", rsp_data); end
        n_vec++; if (rsp_err !== 1'b0) begin n_err++; $display("FAIL reset_rsp_err: got %b want 0", rsp_err); end
        n_vec++; if (mul_start !== 1'b0) begin n_err++; $display("FAIL reset_mul_start: got %b want 0", mul_start); end
        n_vec++; if ({mul_a, mul_b} !== 32'd0) begin n_err++; $display("FAIL reset_mul_ab: got %h/%h want 0/0", mul_a, mul_b); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        rst = 1'b0;
    endtask

    // -----------------------------------------------------------------------
    task automatic test_single;
        bit ok;
        withhold   = 1'b0;
        done_delay = 5;
        set_ops(1, 16'd3, 16'd5);
        req[1] = 1'b1;
        @(negedge clk);  // ISSUE
        n_vec++; if (gnt !== 4'b0010) begin n_err++; $display("FAIL single_gnt: got %b want 0010", gnt); end
        n_vec++; if (mul_start !== 1'b1) begin n_err++; $display("FAIL single_mul_start: got %b want 1", mul_start); end
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy: got %b want 1", busy); end
        req[1] = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);  // WAIT i
            n_vec++;
            if ({mul_a, mul_b, mul_start, rsp_valid} !== {16'd3, 16'd5, 1'b0, 4'b0000}) begin
                n_err++;
                $display("FAIL single_wait%0d: got a=%0d b=%0d start=%b rv=%b want a=3 b=5 start=0 rv=0000",
                         i, mul_a, mul_b, mul_start, rsp_valid);
            end
        end
        @(negedge clk);  // RESP
        n_vec++; if (rsp_valid !== 4'b0010) begin n_err++; $display("FAIL single_rsp_valid: got %b want 0010", rsp_valid); end
        n_vec++; if (rsp_data !== 32'd15) begin n_err++; $display("FAIL single_rsp_data: got %0d want 15", rsp_data); end
        n_vec++; if (rsp_err !== 1'b0) begin n_err++; $display("FAIL single_rsp_err: got %b want 0", rsp_err); end
        @(negedge clk);
        n_vec++; if ({busy, rsp_valid} !== 5'b00000) begin n_err++; $display("FAIL single_after: got busy=%b rv=%b want 0/0000", busy, rsp_valid); end
        wait_idle(5, ok);
    endtask

    // -----------------------------------------------------------------------
    task automatic test_round_robin;
        int exp_ord[5] = '{0, 1, 2, 3, 0};
        int exp_two[3] = '{2, 3, 2};
        int exp_p[4]   = '{3, 6, 9, 12};
        int got[5];
        int gcyc[5];
        int n;
        int cyc;
        int idx;
        bit ok;

        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < NREQ; i++) set_ops(i, 16'(i + 1), 16'd3);
        done_delay = 1;
        req = 4'b1111;
        n = 0;
        cyc = 0;
        while (n < 5 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (gnt !== '0) begin
                got[n]  = oh_idx(gnt);
                gcyc[n] = cyc;
                n++;
            end
            if (rsp_valid !== '0) begin
                idx = oh_idx(rsp_valid);
                n_vec++;
                if (idx < 0 || rsp_data !== 32'(exp_p[idx < 0 ? 0 : idx])) begin
                    n_err++;
                    $display("FAIL rr_data: got rv=%b data=%0d want one-hot with product of owner", rsp_valid, rsp_data);
                end
            end
        end
        req = '0;
        n_vec++; if (n != 5) begin n_err++; $display("FAIL rr_timeout: got %0d grants want 5", n); end
        for (int k = 0; k < n; k++) begin
            n_vec++; if (got[k] != exp_ord[k]) begin n_err++; $display("FAIL rr_order%0d: got %0d want %0d", k, got[k], exp_ord[k]); end
            if (k > 0) begin
                n_vec++;
                if (gcyc[k] - gcyc[k-1] != 4) begin
                    n_err++;
                    $display("FAIL rr_spacing%0d: got %0d cycles want 4", k, gcyc[k] - gcyc[k-1]);
                end
            end
        end
        wait_idle(20, ok);

        // Only requesters 2 and 3 competing, pointer restarted by reset.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        req = 4'b1100;
        n = 0;
        cyc = 0;
        while (n < 3 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (gnt !== '0) begin
                got[n] = oh_idx(gnt);
                n++;
            end
        end
        req = '0;
        n_vec++; if (n != 3) begin n_err++; $display("FAIL rr2_timeout: got %0d grants want 3", n); end
        for (int k = 0; k < n; k++) begin
            n_vec++; if (got[k] != exp_two[k]) begin n_err++; $display("FAIL rr2_order%0d: got %0d want %0d", k, got[k], exp_two[k]); end
        end
        wait_idle(20, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL rr2_idle: got busy=%b want 0", busy); end
    endtask

    // -----------------------------------------------------------------------
    task automatic test_zero_shortcut;
        logic [W-1:0] za[2] = '{16'd0, 16'd7};
        logic [W-1:0] zb[2] = '{16'd9, 16'd0};
        for (int t = 0; t < 2; t++) begin
            set_ops(0, za[t], zb[t]);
            req[0] = 1'b1;
            @(negedge clk);  // RESP directly after IDLE
            n_vec++; if (gnt !== 4'b0001) begin n_err++; $display("FAIL zero%0d_gnt: got %b want 0001", t, gnt); end
            n_vec++; if (rsp_valid !== 4'b0001) begin n_err++; $display("FAIL zero%0d_rsp_valid: got %b want 0001", t, rsp_valid); end
            n_vec++; if ({rsp_data, rsp_err} !== 33'd0) begin n_err++; $display("FAIL zero%0d_data: got %h err=%b want 0/0", t, rsp_data, rsp_err); end
            n_vec++; if (mul_start !== 1'b0) begin n_err++; $display("FAIL zero%0d_start: got %b want 0", t, mul_start); end
            req[0] = 1'b0;
            @(negedge clk);
            n_vec++; if ({busy, mul_start} !== 2'b00) begin n_err++; $display("FAIL zero%0d_after: got busy=%b start=%b want 0/0", t, busy, mul_start); end
        end
    endtask

    // -----------------------------------------------------------------------
    task automatic test_boundary;
        bit ok;
        done_delay = 3;
        set_ops(3, 16'hFFFF, 16'hFFFF);
        req[3] = 1'b1;
        @(negedge clk);
        n_vec++; if (gnt !== 4'b1000) begin n_err++; $display("FAIL max_gnt: got %b want 1000", gnt); end
        req[3] = 1'b0;
        wait_rsp(20, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL max_timeout: got no rsp_valid want 1000"); end
        n_vec++; if (rsp_valid !== 4'b1000) begin n_err++; $display("FAIL max_rsp_valid: got %b want 1000", rsp_valid); end
        n_vec++; if (rsp_data !== 32'hFFFE0001) begin n_err++; $display("FAIL max_rsp_data: got %h want fffe0001", rsp_data); end
        wait_idle(5, ok);
    endtask

    // -----------------------------------------------------------------------
    task automatic test_watchdog;
        bit ok;
        withhold   = 1'b1;
        done_delay = 3;
        set_ops(1, 16'd2, 16'd2);
        req[1] = 1'b1;
        @(negedge clk);  // ISSUE
        n_vec++; if ({gnt, mul_start} !== 5'b00101) begin n_err++; $display("FAIL wd_issue: got gnt=%b start=%b want 0010/1", gnt, mul_start); end
        req[1] = 1'b0;
        for (int j = 1; j <= 7; j++) begin
            @(negedge clk);
            n_vec++; if ({rsp_valid, busy} !== 5'b00001) begin n_err++; $display("FAIL wd_wait%0d: got rv=%b busy=%b want 0000/1", j, rsp_valid, busy); end
        end
        @(negedge clk);  // eight cycles after ISSUE
        n_vec++; if (rsp_valid !== 4'b0010) begin n_err++; $display("FAIL wd_rsp_valid: got %b want 0010", rsp_valid); end
        n_vec++; if (rsp_err !== 1'b1) begin n_err++; $display("FAIL wd_rsp_err: got %b want 1", rsp_err); end
        n_vec++; if (rsp_data !== 32'd0) begin n_err++; $display("FAIL wd_rsp_data: got %h want 0", rsp_data); end
        withhold = 1'b0;
        @(negedge clk);
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL wd_idle: got %b want 0", busy); end

        // Stray done pulse while idle.
        inject_done = 1'b1;
        @(negedge clk);
        inject_done = 1'b0;
        @(negedge clk);
        n_vec++; if ({busy, rsp_valid, mul_start} !== 6'd0) begin n_err++; $display("FAIL spurious_done: got busy=%b rv=%b start=%b want 0", busy, rsp_valid, mul_start); end

        // Pointer must have moved past requester 1: 2 beats 1 now.
        done_delay = 2;
        set_ops(1, 16'd1, 16'd1);
        set_ops(2, 16'd4, 16'd5);
        req = 4'b0110;
        @(negedge clk);
        n_vec++; if (gnt !== 4'b0100) begin n_err++; $display("FAIL wd_rrptr: got %b want 0100", gnt); end
        req = '0;
        wait_rsp(20, ok);
        n_vec++; if ({rsp_valid, rsp_data} !== {4'b0100, 32'd20}) begin n_err++; $display("FAIL wd_next_rsp: got rv=%b data=%0d want 0100/20", rsp_valid, rsp_data); end
        wait_idle(5, ok);
    endtask

    // -----------------------------------------------------------------------
    task automatic test_reset_mid_wait;
        bit ok;
        int seen;
        withhold = 1'b1;
        set_ops(2, 16'd6, 16'd7);
        req[2] = 1'b1;
        @(negedge clk);  // ISSUE
        n_vec++; if (gnt !== 4'b0100) begin n_err++; $display("FAIL mid_gnt: got %b want 0100", gnt); end
        req[2] = 1'b0;
        repeat (2) @(negedge clk);  // WAIT2
        rst = 1'b1;
        @(negedge clk);
        n_vec++;
        if ({gnt, rsp_valid, rsp_data, rsp_err, mul_start, mul_a, mul_b, busy} !== '0) begin
            n_err++;
            $display("FAIL mid_reset_outputs: got gnt=%b rv=%b data=%h err=%b start=%b a=%h b=%h busy=%b want all 0",
                     gnt, rsp_valid, rsp_data, rsp_err, mul_start, mul_a, mul_b, busy);
        end
        rst = 1'b0;
        withhold = 1'b0;
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (rsp_valid !== '0 || busy !== 1'b0) seen++;
        end
        n_vec++; if (seen != 0) begin n_err++; $display("FAIL mid_dropped: got %0d active cycles want 0", seen); end

        done_delay = 2;
        set_ops(0, 16'd5, 16'd5);
        set_ops(3, 16'd2, 16'd2);
        req = 4'b1101;
        @(negedge clk);
        n_vec++; if (gnt !== 4'b0001) begin n_err++; $display("FAIL mid_next_gnt: got %b want 0001", gnt); end
        req = '0;
        wait_rsp(20, ok);
        n_vec++; if ({rsp_valid, rsp_data} !== {4'b0001, 32'd25}) begin n_err++; $display("FAIL mid_next_rsp: got rv=%b data=%0d want 0001/25", rsp_valid, rsp_data); end
        wait_idle(5, ok);
    endtask

    // -----------------------------------------------------------------------
    task automatic test_back_to_back;
        int got[2];
        int gcyc[2];
        int n;
        int cyc;
        int starts;
        set_ops(0, 16'd0, 16'd1);
        set_ops(1, 16'd3, 16'd0);
        req = 4'b0011;
        n = 0;
        cyc = 0;
        starts = 0;
        while (n < 2 && cyc < 50) begin
            @(negedge clk);
            cyc++;
            if (mul_start === 1'b1) starts++;
            if (gnt !== '0) begin
                got[n]  = oh_idx(gnt);
                gcyc[n] = cyc;
                n_vec++;
                if (rsp_valid !== gnt || rsp_data !== 32'd0) begin
                    n_err++;
                    $display("FAIL b2b_rsp%0d: got rv=%b data=%h want rv=gnt=%b data=0", n, rsp_valid, rsp_data, gnt);
                end
                n++;
            end
        end
        req = '0;
        n_vec++; if (n != 2) begin n_err++; $display("FAIL b2b_timeout: got %0d grants want 2", n); end
        if (n == 2) begin
            n_vec++; if (got[0] != 1 || got[1] != 0) begin n_err++; $display("FAIL b2b_order: got %0d,%0d want 1,0", got[0], got[1]); end
            n_vec++; if (gcyc[1] - gcyc[0] != 2) begin n_err++; $display("FAIL b2b_spacing: got %0d want 2", gcyc[1] - gcyc[0]); end
        end
        n_vec++; if (starts != 0) begin n_err++; $display("FAIL b2b_mul_start: got %0d pulses want 0", starts); end
    endtask

    // -----------------------------------------------------------------------
    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_zero_shortcut();
        test_boundary();
        test_watchdog();
        test_reset_mid_wait();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded 200000 ns");
        $fatal(1, "bench timeout");
    end

endmodule
